// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, transaction owner
// and the memory request payload used for both the latched request and the mem_req_* bus.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_D
    } arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant policy: data port wins unless fetch has waited through MAX_DATA_STREAK data grants.
module mem_arb_grant #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic idle,
    input  logic if_valid,
    input  logic d_valid,
    output logic if_grant_c,
    output logic d_grant_c
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                fetch_turn;

    always_comb begin
        fetch_turn = if_valid && (!d_valid || (streak == STREAK_MAX));
        if_grant_c = idle && fetch_turn;
        d_grant_c  = idle && d_valid && !fetch_turn;
    end

    // Count data grants that made a waiting fetch wait longer; any other grant clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (d_grant_c) begin
            if (!if_valid) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
            end
        end else if (if_grant_c) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters, one
// outstanding transaction at a time, with responses routed back to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = MEM_ADDR_W,
    parameter int unsigned DATA_W          = MEM_DATA_W,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_rdata,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    output logic                busy,
    output logic                err_unexp_resp
);

    arb_state_t          state;
    arb_owner_t          owner;
    mem_req_t            req_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                idle_c;
    logic                if_grant_c;
    logic                d_grant_c;

    assign idle_c = (state == IDLE);

    mem_arb_grant #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_grant (
        .clock      (clock),
        .reset      (reset),
        .idle       (idle_c),
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
        .if_grant_c (if_grant_c),
        .d_grant_c  (d_grant_c)
    );

    assign if_req_ready  = if_grant_c;
    assign d_req_ready   = d_grant_c;

    assign mem_req_we    = req_q.we;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_be    = req_q.be;
    assign if_resp_rdata = rdata_q;
    assign d_resp_rdata  = rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= OWNER_IF;
            req_q          <= '0;
            rdata_q        <= '0;
            mem_req_valid  <= 1'b0;
            busy           <= 1'b0;
            if_resp_valid  <= 1'b0;
            d_resp_valid   <= 1'b0;
            err_unexp_resp <= 1'b0;
        end else begin
            if (mem_resp_valid && (state != WAIT)) begin
                err_unexp_resp <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (d_grant_c) begin
                        req_q.we      <= d_req_we;
                        req_q.addr    <= d_req_addr;
                        req_q.wdata   <= d_req_wdata;
                        req_q.be      <= d_req_be;
                        owner         <= OWNER_D;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end else if (if_grant_c) begin
                        // Fetches are always full-word reads.
                        req_q.we      <= 1'b0;
                        req_q.addr    <= if_req_addr;
                        req_q.wdata   <= '0;
                        req_q.be      <= '1;
                        owner         <= OWNER_IF;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q       <= req_q.we ? '0 : mem_resp_rdata;
                        if_resp_valid <= (owner == OWNER_IF);
                        d_resp_valid  <= (owner == OWNER_D);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if_resp_valid <= 1'b0;
                    d_resp_valid  <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-timing reference model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;
    logic        d_req_valid = 1'b0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_addr = '0;
    logic [31:0] d_req_wdata = '0;
    logic [3:0]  d_req_be = '0;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        busy;
    logic        err_unexp_resp;

    int checks = 0;
    int errors = 0;

    // Memory model controls, shared with the tests.
    bit          mem_auto  = 1'b1;
    int          mem_stall = 0;
    int          mem_lat   = 1;
    int          stall_cnt = 0;
    int          resp_cd   = 0;
    logic [31:0] rd_q      = '0;

    mem_port_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_resp_rdata  (if_resp_rdata),
        .d_req_valid    (d_req_valid),
        .d_req_we       (d_req_we),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_be       (d_req_be),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_rdata   (d_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .busy           (busy),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: holds ready low for mem_stall cycles, answers mem_lat cycles after accept.
    // It always returns mem_word(addr), even for stores, so the arbiter must zero store data.
    initial begin : mem_model
        forever begin
            @(negedge clock);
            if (mem_auto) begin
                mem_resp_valid = 1'b0;
                mem_resp_rdata = '0;
                if (resp_cd > 0) begin
                    resp_cd--;
                    if (resp_cd == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = rd_q;
                    end
                end
                mem_req_ready = 1'b0;
                if (mem_req_valid) begin
                    if (stall_cnt >= mem_stall) begin
                        mem_req_ready = 1'b1;
                        stall_cnt     = 0;
                        resp_cd       = mem_lat;
                        rd_q          = mem_word(mem_req_addr);
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clock); #1;
        checks++;
        if ({busy, mem_req_valid, if_resp_valid, d_resp_valid, err_unexp_resp} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got busy/mrv/ifr/dr/err=%b want 00000",
                     {busy, mem_req_valid, if_resp_valid, d_resp_valid, err_unexp_resp});
        end
        checks++;
        if ({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be, if_resp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_regs got addr=%h wdata=%h be=%h rdata=%h want all 0",
                     mem_req_addr, mem_req_wdata, mem_req_be, if_resp_rdata);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        checks++;
        if ({if_req_ready, d_req_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got ifr/dr/busy=%b want 000", {if_req_ready, d_req_ready, busy});
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        #1;
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_ready got if/d=%b want 10", {if_req_ready, d_req_ready});
        end
        @(negedge clock);
        if_req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
            errors++;
            $display("FAIL fetch_issue got v=%b we=%b addr=%h be=%h want v=1 we=0 addr=10 be=f",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_be);
        end
        @(negedge clock); #1;
        checks++;
        if ({if_resp_valid, d_resp_valid, busy} !== 3'b001) begin
            errors++;
            $display("FAIL fetch_wait got ifr/dr/busy=%b want 001", {if_resp_valid, d_resp_valid, busy});
        end
        @(negedge clock); #1;
        checks++;
        if ({if_resp_valid, d_resp_valid} !== 2'b10 || if_resp_rdata !== 32'h0050_0093) begin
            errors++;
            $display("FAIL fetch_resp got if/d=%b rdata=%h want 10 rdata=00500093",
                     {if_resp_valid, d_resp_valid}, if_resp_rdata);
        end
        @(negedge clock); #1;
        checks++;
        if ({if_resp_valid, d_resp_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_done got ifr/dr/busy=%b want 000", {if_resp_valid, d_resp_valid, busy});
        end
    endtask

    task automatic test_store();
        @(negedge clock);
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 32'h20;
        d_req_wdata = 32'hDEAD_BEEF;
        d_req_be    = 4'h3;
        #1;
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL store_ready got if/d=%b want 01", {if_req_ready, d_req_ready});
        end
        @(negedge clock);
        d_req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} !==
            {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3}) begin
            errors++;
            $display("FAIL store_issue got v=%b we=%b addr=%h wdata=%h be=%h want 1 1 20 deadbeef 3",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be);
        end
        @(negedge clock);
        @(negedge clock); #1;
        checks++;
        if ({if_resp_valid, d_resp_valid} !== 2'b01 || d_resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_resp got if/d=%b rdata=%h want 01 rdata=0",
                     {if_resp_valid, d_resp_valid}, d_resp_rdata);
        end
        d_req_we = 1'b0;
    endtask

    task automatic test_contention();
        int  streak = 0;
        int  ngr    = 0;
        int  nresp  = 0;
        bit  exp_d;
        bit  last_d = 1'b0;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h100;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 32'h200;
        for (int c = 0; c < 60 && nresp < 10; c++) begin
            if (c > 0) @(negedge clock);
            if (ngr == 10) begin
                if_req_valid = 1'b0;
                d_req_valid  = 1'b0;
            end
            #1;
            if (if_req_ready && d_req_ready) begin
                errors++;
                $display("FAIL contention_both_ready cycle %0d got if=1 d=1 want at most one", c);
            end
            if (if_resp_valid || d_resp_valid) begin
                checks++;
                if ({if_resp_valid, d_resp_valid} !== (last_d ? 2'b01 : 2'b10) ||
                    (last_d ? d_resp_rdata : if_resp_rdata) !== mem_word(last_d ? 32'h200 : 32'h100)) begin
                    errors++;
                    $display("FAIL contention_resp %0d got if/d=%b ifdata=%h ddata=%h want d_owner=%0d",
                             nresp, {if_resp_valid, d_resp_valid}, if_resp_rdata, d_resp_rdata, last_d);
                end
                nresp++;
            end
            if (if_req_ready || d_req_ready) begin
                exp_d = (streak != MAXS);
                checks++;
                if (d_req_ready !== exp_d) begin
                    errors++;
                    $display("FAIL contention_grant %0d got %s want %s", ngr,
                             d_req_ready ? "D" : "IF", exp_d ? "D" : "IF");
                end
                streak = exp_d ? ((streak < MAXS) ? streak + 1 : streak) : 0;
                last_d = exp_d;
                ngr++;
            end
        end
        checks++;
        if (nresp != 10) begin
            errors++;
            $display("FAIL contention_count got %0d responses want 10", nresp);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_backpressure();
        int resp_c = -1;
        bit unstable = 1'b0;
        mem_stall = 5;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready got %b want 1", if_req_ready);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if_req_valid = 1'b0;
            #1;
            if (c <= 6 && {mem_req_valid, mem_req_we, mem_req_addr, mem_req_be} !==
                          {1'b1, 1'b0, 32'h40, 4'hF}) unstable = 1'b1;
            if (if_resp_valid && resp_c < 0) resp_c = c;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_stable got request change during stall want stable addr=40 be=f we=0 v=1");
        end
        checks++;
        if (resp_c != 8) begin
            errors++;
            $display("FAIL bp_latency got resp at +%0d want +8", resp_c);
        end
        mem_stall = 0;
    endtask

    task automatic test_random();
        int          streak  = 0;
        int          free_at = 0;
        int          resp_at = -1;
        bit          resp_d  = 1'b0;
        logic [31:0] resp_data = '0;
        bit          idle, exp_if, exp_d;
        int          st = 0;
        int          lt = 1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        resp_cd = 0; stall_cnt = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            if_req_valid = ($urandom_range(0, 9) < 6);
            if_req_addr  = $urandom;
            d_req_valid  = ($urandom_range(0, 9) < 6);
            d_req_we     = 1'($urandom_range(0, 1));
            d_req_addr   = $urandom;
            d_req_wdata  = $urandom;
            d_req_be     = 4'($urandom_range(0, 15));
            idle = (c >= free_at);
            if (idle) begin
                st = $urandom_range(0, 2);
                lt = $urandom_range(1, 3);
                mem_stall = st;
                mem_lat   = lt;
            end
            exp_d  = idle && d_req_valid && !(if_req_valid && streak == MAXS);
            exp_if = idle && if_req_valid && !exp_d;
            #1;
            checks++;
            if ({if_req_ready, d_req_ready, busy} !== {exp_if, exp_d, !idle}) begin
                errors++;
                $display("FAIL rand_grant cycle %0d got ifr/dr/busy=%b want %b", c,
                         {if_req_ready, d_req_ready, busy}, {exp_if, exp_d, !idle});
            end
            checks++;
            if ({if_resp_valid, d_resp_valid} !== ((c == resp_at) ? (resp_d ? 2'b01 : 2'b10) : 2'b00)) begin
                errors++;
                $display("FAIL rand_resp_valid cycle %0d got if/d=%b want expected at %0d owner_d=%0d",
                         c, {if_resp_valid, d_resp_valid}, resp_at, resp_d);
            end
            if (c == resp_at) begin
                checks++;
                if ((resp_d ? d_resp_rdata : if_resp_rdata) !== resp_data) begin
                    errors++;
                    $display("FAIL rand_resp_data cycle %0d got %h want %h", c,
                             resp_d ? d_resp_rdata : if_resp_rdata, resp_data);
                end
            end
            if (exp_if || exp_d) begin
                resp_d    = exp_d;
                resp_data = exp_d ? (d_req_we ? 32'h0 : mem_word(d_req_addr)) : mem_word(if_req_addr);
                resp_at   = c + 2 + st + lt;
                free_at   = resp_at + 1;
                streak    = (exp_d && if_req_valid) ? ((streak < MAXS) ? streak + 1 : streak) : 0;
            end
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        repeat (12) @(negedge clock);
        mem_stall = 0;
        mem_lat   = 1;
    endtask

    task automatic test_reset_mid_wait();
        bit stray = 1'b0;
        mem_lat = 4;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h50;
        @(negedge clock);
        if_req_valid = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({busy, mem_req_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_wait_pre got busy/mrv=%b want 10", {busy, mem_req_valid});
        end
        reset = 1'b0;
        #1;
        resp_cd = 0; stall_cnt = 0;
        checks++;
        if ({busy, mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_wait_async got busy/mrv=%b want 00", {busy, mem_req_valid});
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clock); #1;
            if (if_resp_valid || d_resp_valid || err_unexp_resp || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_wait_after got stray resp/err/busy want none");
        end
        // Abort while still holding the request on the bus.
        mem_lat   = 1;
        mem_stall = 10;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h60;
        @(negedge clock);
        if_req_valid = 1'b0;
        @(negedge clock); #1;
        reset = 1'b0;
        #1;
        resp_cd = 0; stall_cnt = 0;
        checks++;
        if ({busy, mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_issue_async got busy/mrv=%b want 00", {busy, mem_req_valid});
        end
        @(negedge clock);
        reset = 1'b1;
        mem_stall = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_spurious_resp();
        bit bad = 1'b0;
        int resp_c = -1;
        @(negedge clock); #1;
        mem_auto = 1'b0;
        @(negedge clock);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({err_unexp_resp, if_resp_valid, d_resp_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL spur_err got err/ifr/dr/busy=%b want 1000",
                     {err_unexp_resp, if_resp_valid, d_resp_valid, busy});
        end
        repeat (3) begin
            @(negedge clock); #1;
            if (err_unexp_resp !== 1'b1 || if_resp_valid || d_resp_valid) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL spur_sticky got err dropped or resp pulse want err=1 no resp");
        end
        mem_auto = 1'b1;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if_req_valid = 1'b0;
            #1;
            if (if_resp_valid && resp_c < 0) begin
                resp_c = c;
                checks++;
                if (if_resp_rdata !== 32'h0050_0093 || d_resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL spur_fetch_data got %h d=%b want 00500093 d=0", if_resp_rdata, d_resp_valid);
                end
            end
        end
        checks++;
        if (resp_c != 3 || err_unexp_resp !== 1'b1) begin
            errors++;
            $display("FAIL spur_fetch got resp at +%0d err=%b want +3 err=1", resp_c, err_unexp_resp);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin : main
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_spurious_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
